// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared types and 50 MHz default timing constants for the
//               push-button debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    // Debouncer states; the counter is only meaningful in the *_WAIT states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Defaults for a 50 MHz clock: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat period.
    localparam int unsigned c_cnt_w           = 20;
    localparam int unsigned c_debounce_cycles = 500000;
    localparam int unsigned c_repeat_delay    = 25000000;
    localparam int unsigned c_repeat_period   = 5000000;

    // Width able to hold the values 0 .. max(a, b).
    function automatic int unsigned rpt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_if
// Description : Button pin in, debounced level and press/release strobes out.
//               The release strobe is carried on key_release because
//               "release" is a reserved word in SystemVerilog.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_debounce_if;
    import key_pkg::*;

    logic key_n;        // raw pin, 0 = pressed, asynchronous
    logic key_level;    // debounced level, 1 = pressed
    logic press;        // one-cycle press strobe (and auto-repeat when enabled)
    logic key_release;  // one-cycle release strobe

    modport master (output key_n, input  key_level, press, key_release);
    modport slave  (input  key_n, output key_level, press, key_release);

endinterface
`default_nettype wire

// File: rtl/key_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module      : key_sync
// Description : Generic two-flop synchroniser with a configurable reset
//               value, shared by the push-button and slide-switch inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module key_sync
    import key_pkg::*;
#(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [WIDTH-1:0]   i_async,
    output logic      [WIDTH-1:0]   o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronises an active-low push-button, filters contact
//               bounce with a stability counter and produces a clean level
//               plus one-cycle press/release strobes.
//               Optional auto-repeat of the press strobe while held is
//               enabled by defining KEY_DEBOUNCE_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned CNT_W           = c_cnt_w,
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles,
    parameter int unsigned REPEAT_DELAY    = c_repeat_delay,
    parameter int unsigned REPEAT_PERIOD   = c_repeat_period
) (
    input  wire logic       clk,
    input  wire logic       rst,
    key_debounce_if.slave   kif
);

    // Last count of a *_WAIT state; the counter stops here and never wraps.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       w_sk_n;
    logic       w_sk;
    key_state_t r_state;
    logic [CNT_W-1:0] r_cnt;

    key_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (kif.key_n),
        .o_sync  (w_sk_n)
    );

    assign w_sk = ~w_sk_n;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int unsigned      c_rpt_w       = rpt_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [c_rpt_w-1:0] c_delay_last  = c_rpt_w'(REPEAT_DELAY - 1);
    localparam logic [c_rpt_w-1:0] c_period_last = c_rpt_w'(REPEAT_PERIOD - 1);

    logic [c_rpt_w-1:0] r_rpt;      // cycles held since entry or last repeat
    logic               r_rpt_on;   // first repeat already issued
    logic [c_rpt_w-1:0] w_rpt_last;

    assign w_rpt_last = r_rpt_on ? c_period_last : c_delay_last;
`else
    localparam int unsigned c_unused_rpt = REPEAT_DELAY + REPEAT_PERIOD;
`endif

    // Debounce FSM: every output is registered and strobes last exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            kif.key_level   <= 1'b0;
            kif.press       <= 1'b0;
            kif.key_release <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            r_rpt           <= '0;
            r_rpt_on        <= 1'b0;
`endif
        end else begin
            kif.press       <= 1'b0;
            kif.key_release <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sk) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_sk) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state       <= PRESSED;
                        r_cnt         <= '0;
                        kif.press     <= 1'b1;
                        kif.key_level <= 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                        r_rpt         <= '0;
                        r_rpt_on      <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!w_sk) begin
                        r_state  <= RELEASE_WAIT;
                        r_cnt    <= '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                        r_rpt    <= '0;
                        r_rpt_on <= 1'b0;
                    end else if (r_rpt == w_rpt_last) begin
                        kif.press <= 1'b1;
                        r_rpt     <= '0;
                        r_rpt_on  <= 1'b1;
                    end else begin
                        r_rpt <= r_rpt + c_rpt_w'(1);
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (w_sk) begin
                        // Bounce back to pressed: no strobe, repeat timing restarts.
                        r_state  <= PRESSED;
                        r_cnt    <= '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                        r_rpt    <= '0;
                        r_rpt_on <= 1'b0;
`endif
                    end else if (r_cnt == c_cnt_last) begin
                        r_state         <= IDLE;
                        r_cnt           <= '0;
                        kif.key_release <= 1'b1;
                        kif.key_level   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
